mult_rr_scheduler: RTL and testbench

//  Round-robin scheduler sharing one pipelined Multiplier (operand regs + product reg)

---
 rtl/mult_rr_scheduler_if.sv | 26 ++
 rtl/mult_rr_scheduler.sv | 89 ++++++++
 tb/tb_mult_rr_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mult_rr_scheduler_if.sv
// Requester and multiplier signals of the round-robin multiplier scheduler.
// The slave modport is the scheduler. The master modport is the requesters plus the multiplier.
interface mult_rr_scheduler_if #(
  parameter int unsigned DATA_BITWIDTH = 8,
  parameter int unsigned NUM_REQ       = 4
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*DATA_BITWIDTH-1:0] req_iact;
  logic [NUM_REQ*DATA_BITWIDTH-1:0] req_wght;
  logic [DATA_BITWIDTH-1:0]         mul_iact;
  logic [DATA_BITWIDTH-1:0]         mul_wght;
  logic [2*DATA_BITWIDTH-1:0]       mul_dout;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [2*DATA_BITWIDTH-1:0]       rsp_data;

  modport master (
    output req_valid, req_iact, req_wght, mul_dout,
    input  req_ready, mul_iact, mul_wght, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_iact, req_wght, mul_dout,
    output req_ready, mul_iact, mul_wght, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler that shares one pipelined multiplier among NUM_REQ requesters.
// Each issued op carries an ID tag through the pipeline so its product returns to the requester that issued it.
module mult_rr_scheduler #(
  parameter int unsigned DATA_BITWIDTH = 8,
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned MUL_LAT       = 2
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               en,
  mult_rr_scheduler_if.slave bus,
  output logic               busy
);
  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [IdW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]           grant_id, cand;
  logic                     found;
  logic [NUM_REQ-1:0]       grant;
  logic [DATA_BITWIDTH-1:0] op_iact, op_wght;
  logic [MUL_LAT-1:0]       tag_vld_q;
  logic [IdW-1:0]           tag_id_q [MUL_LAT];
  logic [NUM_REQ-1:0]       rsp_onehot;

  // Scan from rr_ptr upward with wrap-around. The first valid requester wins.
  // Gating the grant with rstN keeps the operands quiet while reset is held.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && en && rstN && bus.req_valid[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
    grant = '0;
    if (found) grant[grant_id] = 1'b1;
  end

  always_comb begin
    op_iact = '0;
    op_wght = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        op_iact = op_iact | bus.req_iact[i*DATA_BITWIDTH +: DATA_BITWIDTH];
        op_wght = op_wght | bus.req_wght[i*DATA_BITWIDTH +: DATA_BITWIDTH];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found) rr_ptr_d = (grant_id == IdW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  // The tag pipe shifts every cycle with no stall. Its depth matches the multiplier latency.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tag_vld_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_id_q[i] <= '0;
    end else begin
      tag_vld_q[0] <= found;
      tag_id_q[0]  <= grant_id;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  always_comb begin
    rsp_onehot = '0;
    if (tag_vld_q[MUL_LAT-1]) rsp_onehot[tag_id_q[MUL_LAT-1]] = 1'b1;
  end

  assign bus.req_ready = grant;
  assign bus.mul_iact  = op_iact;
  assign bus.mul_wght  = op_wght;
  assign bus.rsp_valid = rsp_onehot;
  assign bus.rsp_data  = tag_vld_q[MUL_LAT-1] ? bus.mul_dout : '0;
  assign busy          = |tag_vld_q;
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed-vector bench for mult_rr_scheduler. Each table row is one clock cycle.
// A 2-stage multiplier model in the bench drives mul_dout.
module tb_mult_rr_scheduler;
  logic clk = 1'b0;
  logic rstN;
  logic en;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;

  mult_rr_scheduler_if #(.DATA_BITWIDTH(8), .NUM_REQ(4)) bus ();

  mult_rr_scheduler #(.DATA_BITWIDTH(8), .NUM_REQ(4), .MUL_LAT(2)) dut (
    .clk  (clk),
    .rstN (rstN),
    .en   (en),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: an operand register stage followed by a product register stage.
  logic [7:0]  a_q, b_q;
  logic [15:0] p_q;
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      a_q <= bus.mul_iact;
      b_q <= bus.mul_wght;
      p_q <= 16'(a_q) * 16'(b_q);
    end
  end
  assign bus.mul_dout = p_q;

  typedef struct {
    logic        en;
    logic [3:0]  valid;
    logic [31:0] iact;
    logic [31:0] wght;
    logic [3:0]  rdy;
    logic [7:0]  mi;
    logic [7:0]  mw;
    logic [3:0]  rv;
    logic [15:0] rd;
    logic        busy;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(logic e, logic [3:0] v, logic [31:0] ia, logic [31:0] wg,
                              logic [3:0] rdy, logic [7:0] mi, logic [7:0] mw,
                              logic [3:0] rv, logic [15:0] rd, logic b);
    vec_t t;
    t.en = e; t.valid = v; t.iact = ia; t.wght = wg; t.rdy = rdy;
    t.mi = mi; t.mw = mw; t.rv = rv; t.rd = rd; t.busy = b;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  localparam logic [31:0] FI = 32'h0504_0302;  // lane i iact = i+2
  localparam logic [31:0] FW = 32'h0D0C_0B0A;  // lane i wght = i+10

  initial begin
    vecs[0]  = mk(1, 4'b0010, 32'h0709_0309, 32'h0B0C_050D, 4'b0010, 3, 5, 4'b0000, 0, 0);
    vecs[1]  = mk(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 0, 1);
    vecs[2]  = mk(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0010, 15, 1);
    vecs[3]  = mk(1, 4'b1000, 32'hFF00_0000, 32'hFF00_0000, 4'b1000, 255, 255, 4'b0000, 0, 0);
    vecs[4]  = mk(1, 4'b0001, 32'h0000_0000, 32'h0000_004D, 4'b0001, 0, 77, 4'b0000, 0, 1);
    vecs[5]  = mk(1, 4'b1111, FI, FW, 4'b0010, 3, 11, 4'b1000, 16'hFE01, 1);
    vecs[6]  = mk(1, 4'b1111, FI, FW, 4'b0100, 4, 12, 4'b0001, 0, 1);
    vecs[7]  = mk(1, 4'b1111, FI, FW, 4'b1000, 5, 13, 4'b0010, 33, 1);
    vecs[8]  = mk(1, 4'b1111, FI, FW, 4'b0001, 2, 10, 4'b0100, 48, 1);
    vecs[9]  = mk(1, 4'b1111, FI, FW, 4'b0010, 3, 11, 4'b1000, 65, 1);
    vecs[10] = mk(1, 4'b1111, FI, FW, 4'b0100, 4, 12, 4'b0001, 20, 1);
    vecs[11] = mk(1, 4'b1111, FI, FW, 4'b1000, 5, 13, 4'b0010, 33, 1);
    vecs[12] = mk(1, 4'b1111, FI, FW, 4'b0001, 2, 10, 4'b0100, 48, 1);
    vecs[13] = mk(1, 4'b1000, FI, FW, 4'b1000, 5, 13, 4'b1000, 65, 1);
    vecs[14] = mk(1, 4'b0101, FI, FW, 4'b0001, 2, 10, 4'b0001, 20, 1);
    vecs[15] = mk(1, 4'b0101, FI, FW, 4'b0100, 4, 12, 4'b1000, 65, 1);
    vecs[16] = mk(0, 4'b1111, FI, FW, 4'b0000, 0, 0, 4'b0001, 20, 1);
    vecs[17] = mk(0, 4'b1111, FI, FW, 4'b0000, 0, 0, 4'b0100, 48, 1);
    vecs[18] = mk(0, 4'b1111, FI, FW, 4'b0000, 0, 0, 4'b0000, 0, 0);
    vecs[19] = mk(1, 4'b1111, FI, FW, 4'b1000, 5, 13, 4'b0000, 0, 0);
    vecs[20] = mk(1, 4'b0000, FI, FW, 4'b0000, 0, 0, 4'b0000, 0, 1);
    vecs[21] = mk(1, 4'b0000, FI, FW, 4'b0000, 0, 0, 4'b1000, 65, 1);
    vecs[22] = mk(1, 4'b0010, FI, FW, 4'b0010, 3, 11, 4'b0000, 0, 0);
    vecs[23] = mk(1, 4'b0010, FI, FW, 4'b0010, 3, 11, 4'b0000, 0, 1);
    vecs[24] = mk(1, 4'b0000, FI, FW, 4'b0000, 0, 0, 4'b0010, 33, 1);
    vecs[25] = mk(1, 4'b0000, FI, FW, 4'b0000, 0, 0, 4'b0010, 33, 1);
    vecs[26] = mk(1, 4'b0000, FI, FW, 4'b0000, 0, 0, 4'b0000, 0, 0);

    // Reset state: grants stay gated even with every requester valid.
    rstN = 1'b0;
    en = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_iact = FI;
    bus.req_wght = FW;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_mul_iact", 32'(bus.mul_iact), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    repeat (2) @(posedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 27; i++) begin
      en = vecs[i].en;
      bus.req_valid = vecs[i].valid;
      bus.req_iact = vecs[i].iact;
      bus.req_wght = vecs[i].wght;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d_mul_iact", i), 32'(bus.mul_iact), 32'(vecs[i].mi));
      chk($sformatf("v%0d_mul_wght", i), 32'(bus.mul_wght), 32'(vecs[i].mw));
      chk($sformatf("v%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].rv));
      chk($sformatf("v%0d_rsp_data", i), 32'(bus.rsp_data), 32'(vecs[i].rd));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      @(posedge clk);
      #1;
    end

    // Reset with an op in flight. rr_ptr is 2 here, so lane 2 is granted first.
    en = 1'b1;
    bus.req_valid = 4'b0100;
    bus.req_iact = 32'h0009_0000;
    bus.req_wght = 32'h0009_0000;
    @(negedge clk);
    chk("inflight_ready", 32'(bus.req_ready), 32'h4);
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0000;
    @(negedge clk);
    chk("inflight_busy", 32'(busy), 32'h1);
    #1;
    rstN = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    chk("midrst_ready", 32'(bus.req_ready), 32'h0);
    chk("midrst_mul_iact", 32'(bus.mul_iact), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("midrst_rsp_valid_c%0d", c), 32'(bus.rsp_valid), 32'h0);
      chk($sformatf("midrst_busy_c%0d", c), 32'(busy), 32'h0);
    end
    // Without reset rr_ptr would be 3 and would grant lane 3. After reset the scan restarts at 0, so lane 1 wins.
    bus.req_valid = 4'b1110;
    bus.req_iact = 32'h0000_0600;
    bus.req_wght = 32'h0000_0700;
    rstN = 1'b1;
    #1;
    chk("postrst_ready", 32'(bus.req_ready), 32'h2);
    chk("postrst_mul_iact", 32'(bus.mul_iact), 32'h6);
    chk("postrst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0000;
    @(negedge clk);
    chk("postrst_rsp_quiet", 32'(bus.rsp_valid), 32'h0);
    chk("postrst_busy1", 32'(busy), 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("postrst_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    chk("postrst_rsp_data", 32'(bus.rsp_data), 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
